// File: rtl/rmu_arbiter.sv
// rmu_arbiter: round-robin sharing of one registered rmu multiplier across NREQ lanes,
// tracking its latency and returning tagged products through a credit-protected FIFO.
module rmu_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_mode,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_mode,
  input  logic [2*WIDTH-1:0]      mul_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_id,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    busy
);
  localparam int AW = $clog2(RSP_DEPTH);
  logic [1:0] last, gnt, s1_id, s2_id;
  logic s1_v, s2_v, any, credit, acc, push, pop;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [1:0] mem_id [RSP_DEPTH];
  logic [2*WIDTH-1:0] mem_data [RSP_DEPTH];
  // scan from lowest priority upward so the highest-priority valid lane wins
  always_comb begin
    gnt = last;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[last + 2'(k)]) begin
        gnt = last + 2'(k);
        any = 1'b1;
      end
  end
  // everything accepted but not yet popped must fit in the FIFO
  assign credit = int'(cnt) + int'(s1_v) + int'(s2_v) < RSP_DEPTH;
  assign req_ready = (rst && any && credit) ? NREQ'(1) << gnt : '0;
  assign acc = |req_ready;
  assign push = s2_v;
  assign pop = rsp_valid & rsp_ready;
  assign rsp_valid = cnt != '0;
  assign rsp_id = rsp_valid ? mem_id[rp] : '0;
  assign rsp_data = rsp_valid ? mem_data[rp] : '0;
  assign busy = s1_v | s2_v | rsp_valid;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wp] <= s2_id;
      mem_data[wp] <= mul_result;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= 2'd3;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_id <= '0;
      s2_id <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_mode <= 1'b0;
    end else begin
      if (acc) begin
        last <= gnt;
        mul_a <= req_a[gnt*WIDTH +: WIDTH];
        mul_b <= req_b[gnt*WIDTH +: WIDTH];
        mul_mode <= req_mode[gnt];
      end
      s1_v <= acc;
      s1_id <= gnt;
      s2_v <= s1_v;
      s2_id <= s1_id;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_rmu_arbiter.sv
// tb_rmu_arbiter: directed and randomized checks of rmu_arbiter against a queue-based model,
// with a behavioural one-cycle rmu attached.
module tb_rmu_arbiter;
  logic clk = 1'b0, rst = 1'b0, rsp_ready = 1'b0;
  logic [3:0] rv = '0, rm = '0, req_ready;
  logic [31:0] ra = '0, rb = '0;
  logic [7:0] mul_a, mul_b;
  logic mul_mode, rsp_valid, busy;
  logic [15:0] mul_result, rsp_data;
  logic [1:0] rsp_id;
  int n_cmp = 0, n_bad = 0;

  rmu_arbiter #(.WIDTH(8), .NREQ(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready), .req_a(ra), .req_b(rb),
    .req_mode(rm), .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [15:0] prod(logic [7:0] a, logic [7:0] b, logic m);
    int x, y;
    x = m ? int'($signed(a)) : int'(a);
    y = m ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  // rmu stand-in: registered product, held in reset by the inverted arbiter reset
  always @(posedge clk) mul_result <= !rst ? 16'h0 : prod(mul_a, mul_b, mul_mode);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: every accepted op sits in one ordered queue until popped
  typedef struct { logic [1:0] id; logic [15:0] d; int t; } item_t;
  item_t q[$];
  int cyc = 0, mlast = 3;
  bit armed = 0;
  logic [7:0] ea, eb;
  logic em;
  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    bit hv;
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && rv[(mlast + k) % 4]) g = (mlast + k) % 4;
    er = (rst && g >= 0 && q.size() < 4) ? 4'(1 << g) : 4'h0;
    hv = q.size() > 0 && q[0].t <= cyc;
    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(hv));
      if (hv) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("mul_ops", {15'h0, mul_mode, mul_a, mul_b}, {15'h0, em, ea, eb});
    end
    if (!rst) begin
      q.delete();
      mlast = 3;
      ea = 0; eb = 0; em = 0;
      armed = 1;
    end else begin
      if (hv && rsp_ready) void'(q.pop_front());
      if (er != 0) begin
        ea = ra[g*8 +: 8]; eb = rb[g*8 +: 8]; em = rm[g];
        q.push_back('{id: 2'(g), d: prod(ea, eb, em), t: cyc + 3});
        mlast = g;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0; tick(); rst = 1;
  endtask

  task automatic do_one(int lane, logic [7:0] a, logic [7:0] b, logic m, logic [15:0] exp);
    int lat;
    bit got;
    rv = 4'(1 << lane); ra[lane*8 +: 8] = a; rb[lane*8 +: 8] = b; rm[lane] = m; rsp_ready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = req_ready[lane];
      if (!got) tick();
    end
    chk("accept", 32'(got), 1);
    tick(); rv = 0; lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 10) begin tick(); lat++; @(negedge clk); end
    chk("latency", lat, 3);
    chk("one_id", 32'(rsp_id), 32'(lane));
    chk("one_data", 32'(rsp_data), 32'(exp));
    tick(); @(negedge clk);
    chk("busy_after_pop", 32'(busy), 0);
    tick();
  endtask

  initial begin
    logic [3:0] acc;
    logic [1:0] hid;
    logic [15:0] hd;
    int n;
    tick(); tick();
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 0);
    rv = 4'hF; @(negedge clk);
    chk("ready_in_reset_valid", 32'(req_ready), 0);
    rv = 0; tick(); rst = 1;
    @(negedge clk);
    chk("reset_outs", {busy, rsp_valid, rsp_id, rsp_data, mul_mode, mul_a, mul_b}, 0);
    tick();
    do_one(2, 8'hFF, 8'h02, 0, 16'h01FE);
    do_one(1, 8'hFF, 8'h02, 1, 16'hFFFE);
    do_one(0, 8'h80, 8'h80, 1, 16'h4000);
    do_one(0, 8'h80, 8'h80, 0, 16'h4000);
    do_one(3, 8'hFF, 8'hFF, 0, 16'hFE01);
    // all lanes contending: strict rotation, responses back to back
    do_reset(); rv = 4'hF; rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      if (i >= 3) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 1);
        chk("rr_rsp_id", 32'(rsp_id), 32'((i - 3) % 4));
      end
      tick();
    end
    rv = 0; repeat (6) tick();
    // backpressure
    do_reset(); rv = 4'h1; ra[7:0] = 8'h11; rb[7:0] = 8'h07; rsp_ready = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); n += int'(req_ready[0]); tick();
    end
    chk("bp_accepts", n, 4);
    @(negedge clk);
    chk("bp_ready_low", 32'(req_ready), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    hid = rsp_id; hd = rsp_data;
    tick(); @(negedge clk);
    chk("bp_hold", {rsp_id, rsp_data}, {hid, hd});
    tick(); rsp_ready = 1;
    @(negedge clk); chk("bp_no_credit_on_pop", 32'(req_ready), 0);
    tick();
    @(negedge clk); chk("bp_resume", 32'(req_ready), 1);
    tick(); rv = 0; repeat (8) tick();
    // fairness between lanes 0 and 3 once last=0
    do_reset(); rv = 4'h1;
    @(negedge clk); chk("fair_seed", 32'(req_ready), 1);
    tick(); rv = 4'h9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("fair_grant", 32'(req_ready), (i % 2 == 0) ? 32'h8 : 32'h1); tick();
    end
    rv = 0; repeat (6) tick();
    // reset with two ops in flight and one queued
    do_reset(); rsp_ready = 0; rv = 4'h1; ra[7:0] = 8'h5A; rb[7:0] = 8'h33;
    repeat (3) tick();
    rv = 0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_valid", 32'(rsp_valid), 1);
    do_reset();
    @(negedge clk);
    chk("mid_reset_outs", {busy, rsp_valid, rsp_id, rsp_data, mul_mode, mul_a, mul_b}, 0);
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin tick(); @(negedge clk); chk("mid_no_stale", 32'(rsp_valid), 0); end
    tick();
    do_one(3, 8'h12, 8'h34, 0, 16'h03A8);
    // randomized traffic; lanes hold operands until accepted
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = req_ready & rv;
      tick();
      for (int l = 0; l < 4; l++)
        if (acc[l] || !rv[l]) begin
          rv[l] = 1'($urandom_range(0, 1));
          ra[l*8 +: 8] = 8'($urandom); rb[l*8 +: 8] = 8'($urandom); rm[l] = 1'($urandom);
        end
      rsp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) != 0;
    end
    rst = 1; rv = 0; rsp_ready = 1;
    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
